// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared uart_tx.
// master = arbiter side, slave = requester/serializer side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              done;
  logic                            err;
  logic [$clog2(NUM_REQ)-1:0]      owner;
  logic                            active;
  logic                            uart_tx_en;
  logic [PAYLOAD_BITS-1:0]         uart_tx_data;
  logic                            uart_tx_busy;

  modport master (
    input  req, req_data, uart_tx_busy,
    output gnt, done, err, owner, active, uart_tx_en, uart_tx_data
  );

  modport slave (
    output req, req_data, uart_tx_busy,
    input  gnt, done, err, owner, active, uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one uart_tx: registered gnt/uart_tx_en one cycle after req in IDLE, done after busy falls.
// Optional wait-state watchdog under UART_TX_ARBITER_WDOG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
`ifdef UART_TX_ARBITER_WDOG_EN
  ,
  parameter int WDOG_CYCLES  = 65536
`endif
) (
  input logic               clk,
  input logic               resetn,
  uart_tx_arbiter_if.master bus
);
  localparam int OW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]              state;
  logic [OW-1:0]           last;
  logic [OW-1:0]           owner_q;
  logic [OW-1:0]           pick;
  logic                    pick_vld;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [NUM_REQ-1:0]      done_q;
  logic                    err_q;
  logic                    active_q;
  logic                    tx_en_q;
  logic [PAYLOAD_BITS-1:0] tx_data_q;
  logic [PAYLOAD_BITS-1:0] slot [NUM_REQ];
  logic                    wdog_expire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = bus.req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Scan from last+NUM_REQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    logic [OW:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last} + (OW+1)'(k);
      if (idx >= (OW+1)'(NUM_REQ)) begin
        idx = idx - (OW+1)'(NUM_REQ);
      end
      if (bus.req[idx[OW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[OW-1:0];
      end
    end
  end

`ifdef UART_TX_ARBITER_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES);

  logic [CW-1:0] wdog_cnt;

  assign wdog_expire = (state != IDLE) && (wdog_cnt == CW'(WDOG_CYCLES - 1));

  // Held at zero in IDLE, so every wait-state entry starts from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt <= '0;
    end else if (state == IDLE || (state == WAIT_BUSY && bus.uart_tx_busy) || wdog_expire) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      last      <= OW'(NUM_REQ - 1);
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tx_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && !bus.uart_tx_busy) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= slot[pick];
            gnt_q     <= NUM_REQ'(1) << pick;
            owner_q   <= pick;
            last      <= pick;
            active_q  <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (bus.uart_tx_busy) begin
            state <= WAIT_DONE;
          end else if (wdog_expire) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state    <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!bus.uart_tx_busy) begin
            done_q   <= NUM_REQ'(1) << owner_q;
            active_q <= 1'b0;
            state    <= IDLE;
          end else if (wdog_expire) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.owner        = owner_q;
  assign bus.active       = active_q;
  assign bus.uart_tx_en   = tx_en_q;
  assign bus.uart_tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the serializer busy flag is driven by hand.
module tb_uart_tx_arbiter;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .PAYLOAD_BITS(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .PAYLOAD_BITS(8)
`ifdef UART_TX_ARBITER_WDOG_EN
    ,
    .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{1, 2, 3, 0, 1};

    bus.req          = '0;
    bus.req_data     = '0;
    bus.uart_tx_busy = 1'b0;
    resetn           = 1'b0;
    step();
    step();
    chk("rst_gnt",    bus.gnt,          0);
    chk("rst_done",   bus.done,         0);
    chk("rst_err",    bus.err,          0);
    chk("rst_active", bus.active,       0);
    chk("rst_en",     bus.uart_tx_en,   0);
    chk("rst_data",   bus.uart_tx_data, 0);
    chk("rst_owner",  bus.owner,        0);
    resetn = 1'b1;

    // Single request from requester 0
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
    bus.req      = 4'b0001;
    step();
    chk("single_gnt",    bus.gnt,          32'h1);
    chk("single_en",     bus.uart_tx_en,   1);
    chk("single_data",   bus.uart_tx_data, 32'hA5);
    chk("single_owner",  bus.owner,        0);
    chk("single_active", bus.active,       1);
    bus.req = '0;
    step();
    chk("single_gnt_off", bus.gnt,          0);
    chk("single_en_off",  bus.uart_tx_en,   0);
    chk("single_hold",    bus.uart_tx_data, 32'hA5);
    chk("single_act_wb",  bus.active,       1);
    bus.uart_tx_busy = 1'b1;
    repeat (3) begin
      step();
      chk("single_no_done", bus.done,   0);
      chk("single_act_wd",  bus.active, 1);
    end
    bus.uart_tx_busy = 1'b0;
    step();
    chk("single_done",    bus.done,   32'h1);
    chk("single_act_end", bus.active, 0);
    step();
    chk("single_done_off", bus.done,  0);
    chk("single_owner_kp", bus.owner, 0);

    // Round-robin with every requester held; last grant was 0
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req      = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      step();
      chk("rr_gnt",   bus.gnt,          32'h1 << exp_order[f]);
      chk("rr_en",    bus.uart_tx_en,   1);
      chk("rr_data",  bus.uart_tx_data, 32'h10 + exp_order[f]);
      chk("rr_owner", bus.owner,        exp_order[f]);
      bus.uart_tx_busy = 1'b1;
      step();
      chk("rr_gnt_busy", bus.gnt,        0);
      chk("rr_en_busy",  bus.uart_tx_en, 0);
      chk("rr_act_busy", bus.active,     1);
      bus.uart_tx_busy = 1'b0;
      if (f == 4) bus.req = '0;
      step();
      chk("rr_done",   bus.done,   32'h1 << exp_order[f]);
      chk("rr_act_end", bus.active, 0);
    end

    // Skip idle requesters: last = 1, pending 0 and 2
    bus.req = 4'b0101;
    step();
    chk("skip_gnt2",   bus.gnt,   32'h4);
    chk("skip_owner2", bus.owner, 2);
    bus.req = 4'b0001;
    bus.uart_tx_busy = 1'b1;
    step();
    bus.uart_tx_busy = 1'b0;
    step();
    chk("skip_done2", bus.done, 32'h4);
    step();
    chk("skip_gnt0",   bus.gnt,   32'h1);
    chk("skip_owner0", bus.owner, 0);
    bus.req = '0;
    bus.uart_tx_busy = 1'b1;
    step();
    bus.uart_tx_busy = 1'b0;
    step();
    chk("skip_done0", bus.done, 32'h1);

    // Busy already high in IDLE blocks arbitration
    bus.uart_tx_busy = 1'b1;
    bus.req          = 4'b0010;
    repeat (3) begin
      step();
      chk("bidle_no_gnt", bus.gnt,    0);
      chk("bidle_no_act", bus.active, 0);
    end
    bus.uart_tx_busy = 1'b0;
    step();
    chk("bidle_gnt",   bus.gnt,   32'h2);
    chk("bidle_owner", bus.owner, 1);
    bus.req = '0;
    bus.uart_tx_busy = 1'b1;
    step();
    chk("bidle_act_wd", bus.active, 1);

    // Asynchronous reset while in WAIT_DONE
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_active", bus.active,       0);
    chk("mrst_en",     bus.uart_tx_en,   0);
    chk("mrst_owner",  bus.owner,        0);
    chk("mrst_data",   bus.uart_tx_data, 0);
    chk("mrst_gnt",    bus.gnt,          0);
    bus.uart_tx_busy = 1'b0;
    step();
    chk("mrst_no_done", bus.done, 0);
    resetn  = 1'b1;
    bus.req = 4'b1000;
    step();
    chk("mrst_gnt3",   bus.gnt,          32'h8);
    chk("mrst_owner3", bus.owner,        3);
    chk("mrst_data3",  bus.uart_tx_data, 32'h13);
    bus.req = '0;
    bus.uart_tx_busy = 1'b1;
    step();
    bus.uart_tx_busy = 1'b0;
    step();
    chk("mrst_done3", bus.done, 32'h8);

    // Serializer never raises busy after a grant; requester 2 waits behind it
    bus.req = 4'b0001;
    step();
    chk("wd_gnt0", bus.gnt, 32'h1);
    bus.req = 4'b0100;
`ifdef UART_TX_ARBITER_WDOG_EN
    repeat (15) begin
      step();
      chk("wd_err_low", bus.err,    0);
      chk("wd_act_hi",  bus.active, 1);
    end
    step();
    chk("wd_err",     bus.err,    1);
    chk("wd_act_end", bus.active, 0);
    chk("wd_no_done", bus.done,   0);
    step();
    chk("wd_err_off", bus.err,   0);
    chk("wd_gnt2",    bus.gnt,   32'h4);
    chk("wd_owner2",  bus.owner, 2);
`else
    repeat (20) begin
      step();
      chk("nowd_err",    bus.err,    0);
      chk("nowd_act_hi", bus.active, 1);
    end
    bus.uart_tx_busy = 1'b1;
    step();
    bus.uart_tx_busy = 1'b0;
    step();
    chk("nowd_done0", bus.done, 32'h1);
    step();
    chk("nowd_gnt2",   bus.gnt,   32'h4);
    chk("nowd_owner2", bus.owner, 2);
`endif
    bus.req = '0;
    bus.uart_tx_busy = 1'b1;
    step();
    bus.uart_tx_busy = 1'b0;
    step();
    chk("tail_done2", bus.done, 32'h4);
    chk("tail_err",   bus.err,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ independent requesters.
- Picks one pending requester by round-robin and issues a single-cycle tx_en with that requester's byte.
- Tracks the serializer's busy flag through the frame, then signals completion to the owner.
- Sits between the command/debug sources and the uart_tx instance; the only block that drives uart_tx_en / uart_tx_data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAYLOAD_BITS, 8, byte width; must match the uart_tx instance.
- WDOG_CYCLES, 65536, watchdog limit in clk cycles per wait state (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held high with stable data until gnt.
- req_data  input  NUM_REQ*PAYLOAD_BITS  requester i byte in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: byte captured.
- done  output  NUM_REQ  one-hot, one-cycle pulse: frame fully sent.
- err  output  1  one-cycle pulse: watchdog abort (tied 0 without the macro).
- owner  output  $clog2(NUM_REQ)  index of current/last granted requester.
- active  output  1  high from grant until done/err.
- uart_tx_en  output  1  start pulse to uart_tx.
- uart_tx_data  output  PAYLOAD_BITS  byte to uart_tx.
- uart_tx_busy  input  1  busy flag from uart_tx.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE; gnt=0, done=0, err=0, active=0, uart_tx_en=0, uart_tx_data=0, owner=0.
  - Internal last pointer = NUM_REQ-1, so requester 0 wins first.
  - An in-flight frame is abandoned; no done pulse.
- All outputs registered.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req and uart_tx_busy==0: select the first set req bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Next edge: uart_tx_en=1, uart_tx_data=selected slice, gnt[sel]=1, owner=sel, last=sel, active=1; state goes to WAIT_BUSY.
  - If uart_tx_busy==1 in IDLE (foreign/stale frame): no grant; wait.
- WAIT_BUSY:
  - uart_tx_en and gnt return to 0 on the first edge, so each is exactly one cycle high.
  - Stay until uart_tx_busy==1, then go to WAIT_DONE.
  - uart_tx_data is held until the state is left.
- WAIT_DONE:
  - Stay while uart_tx_busy==1.
  - On uart_tx_busy==0 at the next edge: done[owner]=1 (one cycle), active=0; go to IDLE.
- Latency:
  - req sampled in IDLE gives gnt and uart_tx_en on the next cycle.
  - Minimum one IDLE cycle between done and the next gnt.
- req is ignored outside IDLE. A requester must drop req the cycle after gnt, otherwise it is re-arbitrated as a new byte.
- A requester with req held continuously receives every NUM_REQ-th slot when all requesters are active; no starvation.
- Simultaneous requests: exactly one gnt per frame; the others remain pending.
- owner keeps its value after done until the next grant.

Optional Feature:
- Macro: UART_TX_ARBITER_WDOG_EN.
- Defined:
  - A cycle counter clears on every state entry and increments in WAIT_BUSY and WAIT_DONE.
  - If it reaches WDOG_CYCLES-1 without the exit condition: next edge err=1 (one cycle), active=0, no done, state goes to IDLE.
  - last still advances past the aborted owner.
- Undefined:
  - No counter; err is constant 0.
  - Wait states are unbounded.

Test Plan:
- Single request: req=4'b0001, byte 0xA5, uart_tx (BAUD_TICKS=4) attached -> gnt[0] and uart_tx_en high one cycle with uart_tx_data=0xA5; line shows start, 10100101 LSB-first, stop; done[0] once after busy falls.
- Round-robin: req=4'b1111 held, bytes 0x10,0x11,0x12,0x13 -> grant order 0,1,2,3,0; exactly one uart_tx_en per frame; no gnt while active=1.
- Skip idle requesters: after a grant to 1, req=4'b0101 -> next grant 2, then 0.
- Busy at idle: force uart_tx_busy=1 with req=4'b0010 -> no gnt until busy=0, then gnt[1] the following cycle.
- Reset mid-frame: assert resetn=0 during WAIT_DONE -> all outputs 0 immediately, no done; after release with req=4'b1000 -> grant 3 (scan starts at 0, finds 3).
- Watchdog (macro defined, WDOG_CYCLES=16): uart_tx_busy stuck 0 after grant -> err pulses 16 cycles after WAIT_BUSY entry, active=0, no done[*], next pending req granted.
